// File: rtl/instr_queue_pkg.sv
// Shared core definitions for the fetch/decode decoupling queue.
// Provides the filter FSM state type and the instruction size constant.
package instr_queue_pkg;

    localparam int unsigned CoreXlen      = 32;
    localparam int unsigned InstrSizeByte = CoreXlen / 8;

    typedef enum logic {
        IQ_DROP = 1'b0,
        IQ_RUN  = 1'b1
    } iq_state_t;

endpackage

// File: rtl/iq_storage.sv
// Entry storage for instr_queue: DEPTH x WIDTH register array, one write
// port, one asynchronous read port, intentionally not reset.
//   clk   : clock
//   we    : write enable
//   waddr : write index, wdata : write entry
//   raddr : read index,  rdata : read entry (combinational)
module iq_storage #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_queue.sv
// Decoupling queue between fetch and decode with skid-based backpressure
// and a PC filter that discards stale fetch output after reset/redirect.
//   clk_i/rst_ni          : clock, async active-low reset
//   boot_addr_i           : first expected PC after reset
//   instr_valid_i/pc/instr: fetch output; instr_ready_o back to fetch
//   flush_i/flush_pc_i    : redirect, empties queue and re-arms the filter
//   instr_valid_o/pc/instr, instr_ready_i : decoder stream
//   count_o               : occupancy; overflow_o : sticky overflow flag
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SKID  = 2,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-1:0] boot_addr_i,
    input  logic            instr_valid_i,
    input  logic [XLEN-1:0] instr_pc_i,
    input  logic [XLEN-1:0] instr_i,
    output logic            instr_ready_o,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_pc_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic [XLEN-1:0] instr_o,
    input  logic            instr_ready_i,
    output logic [CW-1:0]   count_o,
    output logic            overflow_o
);

    iq_state_t       state_q;
    logic            boot_sel_q;
    logic [XLEN-1:0] expect_q;
    logic [PW-1:0]   rd_q;
    logic [PW-1:0]   wr_q;
    logic [CW-1:0]   count_q;
    logic            overflow_q;

    logic [XLEN-1:0] expect_pc;
    logic            full;
    logic            pc_ok;
    logic            accept;
    logic            push;
    logic            pop;
    logic [2*XLEN-1:0] rdata;

    // Until the first redirect, the expected PC tracks boot_addr_i
    // directly, so reset never has to load a non-constant value.
    assign expect_pc = boot_sel_q ? boot_addr_i : expect_q;

    assign full   = (count_q == CW'(DEPTH));
    assign pc_ok  = (state_q == IQ_RUN) || (instr_pc_i == expect_pc);
    assign accept = instr_valid_i && pc_ok && !flush_i;
    assign pop    = instr_valid_o && instr_ready_i;
    // A full queue still accepts when the head leaves in the same cycle.
    assign push   = accept && (!full || pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IQ_DROP;
            boot_sel_q <= 1'b1;
            expect_q   <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (flush_i) begin
            state_q    <= IQ_DROP;
            boot_sel_q <= 1'b0;
            expect_q   <= flush_pc_i;
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
        end else begin
            if (accept && state_q == IQ_DROP) begin
                state_q <= IQ_RUN;
            end
            if (accept && full && !pop) begin
                overflow_q <= 1'b1;
            end
            if (push) begin
                wr_q <= wr_q + PW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    iq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_storage (
        .clk   (clk_i),
        .we    (push),
        .waddr (wr_q),
        .wdata ({instr_pc_i, instr_i}),
        .raddr (rd_q),
        .rdata (rdata)
    );

    assign instr_pc_o    = rdata[2*XLEN-1:XLEN];
    assign instr_o       = rdata[XLEN-1:0];
    assign instr_valid_o = (count_q != '0);
    assign instr_ready_o = ((32'(count_q) + 32'(SKID)) < 32'(DEPTH));
    assign count_o       = count_q;
    assign overflow_o    = overflow_q;

endmodule
